// File: rtl/rx_agc_64k.sv
// Closed-loop AGC for the 64 kHz I/Q stream: 3-stage scale/round/saturate datapath
// plus a windowed |I|+|Q| envelope loop that steers the Q4.12 gain toward TARGET.
`timescale 1ns/1ps
module rx_agc_64k #(
    parameter int          WIN_LOG2  = 6,
    parameter logic [15:0] TARGET    = 16'd8192,
    parameter logic [15:0] HYST      = 16'd1024,
    parameter int          STEP_SH   = 4,
    parameter logic [15:0] GAIN_INIT = 16'h1000,
    parameter logic [15:0] GAIN_MIN  = 16'h0100,
    parameter int          LOCK_CNT  = 4
) (
    input  logic        clk_200m,
    input  logic        cfg_rst,
    input  logic [15:0] data_64k_i_in,
    input  logic [15:0] data_64k_q_in,
    input  logic        data_64k_in_en,
    input  logic        agc_bypass,
    input  logic        agc_freeze,
    output logic [15:0] data_agc_i_out,
    output logic [15:0] data_agc_q_out,
    output logic        data_agc_out_en,
    output logic [15:0] agc_gain,
    output logic        agc_lock
);

    localparam int AW = 17 + WIN_LOG2;
    localparam int LW = $clog2(LOCK_CNT + 1);
    localparam logic [16:0] TH_HI = {1'b0, TARGET} + {1'b0, HYST};
    localparam logic [16:0] TH_LO = (HYST > TARGET) ? 17'd0 : ({1'b0, TARGET} - {1'b0, HYST});

    typedef enum logic [1:0] {S_ACC, S_EVAL, S_UPD} state_t;

    logic               v1_q, v2_q, v3_q;
    logic [15:0]        i1_q, q1_q;
    logic signed [32:0] pi_q, pq_q, pi_d, pq_d;
    logic [15:0]        oi_q, oq_q;
    logic [15:0]        g_eff;

    logic [AW-1:0]       acc_q, acc_d, acc_sum;
    logic [WIN_LOG2-1:0] cnt_q, cnt_d;
    logic [16:0]         mean_q, mean_d, mag;
    logic                wrap;

    state_t      state_q, state_d;
    logic        hi_q, hi_d, lo_q, lo_d;
    logic [15:0] gain_q, gain_d;
    logic [LW-1:0] lcnt_q, lcnt_d;
    logic [16:0] g_dec, g_inc;

    function automatic logic [15:0] rnd_sat(input logic signed [32:0] p);
        logic signed [33:0] r;
        r = {p[32], p} + 34'sd2048;
        r = r >>> 12;
        if (r > 34'sd32767)
            return 16'h7FFF;
        else if (r < -34'sd32768)
            return 16'h8000;
        else
            return r[15:0];
    endfunction

    function automatic logic [15:0] abs16(input logic [15:0] x);
        return x[15] ? (~x + 16'd1) : x;
    endfunction

    // Gain is sampled at S2, so a bypass toggle only affects samples not yet past S1.
    always_comb begin
        g_eff = agc_bypass ? 16'h1000 : gain_q;
        pi_d  = {{17{i1_q[15]}}, i1_q} * {17'd0, g_eff};
        pq_d  = {{17{q1_q[15]}}, q1_q} * {17'd0, g_eff};
    end

    always_ff @(posedge clk_200m) begin
        if (cfg_rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            i1_q <= '0;
            q1_q <= '0;
            pi_q <= '0;
            pq_q <= '0;
            oi_q <= '0;
            oq_q <= '0;
        end else begin
            v1_q <= data_64k_in_en;
            v2_q <= v1_q;
            v3_q <= v2_q;
            if (data_64k_in_en) begin
                i1_q <= data_64k_i_in;
                q1_q <= data_64k_q_in;
            end
            if (v1_q) begin
                pi_q <= pi_d;
                pq_q <= pq_d;
            end
            if (v2_q) begin
                oi_q <= rnd_sat(pi_q);
                oq_q <= rnd_sat(pq_q);
            end
        end
    end

    always_comb begin
        mag     = {1'b0, abs16(oi_q)} + {1'b0, abs16(oq_q)};
        acc_sum = acc_q + AW'(mag);
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        mean_d  = mean_q;
        wrap    = 1'b0;
        if (v3_q && !agc_bypass) begin
            cnt_d = cnt_q + WIN_LOG2'(1);
            if (cnt_q == '1) begin
                wrap   = 1'b1;
                acc_d  = '0;
                mean_d = acc_sum[AW-1:WIN_LOG2];
            end else begin
                acc_d = acc_sum;
            end
        end
    end

    always_comb begin
        g_dec = {1'b0, gain_q} - {1'b0, gain_q >> STEP_SH};
        g_inc = {1'b0, gain_q} + {1'b0, gain_q >> STEP_SH} + 17'd1;
        if (g_dec < {1'b0, GAIN_MIN})
            g_dec = {1'b0, GAIN_MIN};
        if (g_inc[16])
            g_inc = 17'h0FFFF;
    end

    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        lcnt_d  = lcnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_ACC: begin
                if (wrap)
                    state_d = S_EVAL;
            end
            S_EVAL: begin
                hi_d    = mean_q > TH_HI;
                lo_d    = mean_q < TH_LO;
                state_d = S_UPD;
            end
            S_UPD: begin
                state_d = S_ACC;
                if (!agc_freeze) begin
                    if (hi_q) begin
                        gain_d = g_dec[15:0];
                        lcnt_d = '0;
                    end else if (lo_q) begin
                        gain_d = g_inc[15:0];
                        lcnt_d = '0;
                    end else if (lcnt_q != LW'(LOCK_CNT)) begin
                        lcnt_d = lcnt_q + LW'(1);
                    end
                end
            end
            default: state_d = S_ACC;
        endcase
        if (agc_bypass) begin
            state_d = S_ACC;
            gain_d  = gain_q;
            lcnt_d  = lcnt_q;
        end
    end

    always_ff @(posedge clk_200m) begin
        if (cfg_rst) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            mean_q  <= '0;
            state_q <= S_ACC;
            hi_q    <= 1'b0;
            lo_q    <= 1'b0;
            gain_q  <= GAIN_INIT;
            lcnt_q  <= '0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            mean_q  <= mean_d;
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            gain_q  <= gain_d;
            lcnt_q  <= lcnt_d;
        end
    end

    assign data_agc_i_out  = oi_q;
    assign data_agc_q_out  = oq_q;
    assign data_agc_out_en = v3_q;
    assign agc_gain        = gain_q;
    assign agc_lock        = (lcnt_q == LW'(LOCK_CNT));

endmodule

// File: tb/tb_rx_agc_64k.sv
// Directed bench for rx_agc_64k: vector tables for scaling/rounding plus
// hand-written sequences for window updates, lock, clamp and mid-window reset.
`timescale 1ns/1ps
module tb_rx_agc_64k;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] di = '0, dq = '0;
    logic        den = 1'b0;
    logic        byp = 1'b0, frz = 1'b0;
    logic [15:0] oi, oq, gain;
    logic        oen, lock;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic signed [15:0] i;
        logic signed [15:0] q;
        int                 ei;
        int                 eq;
    } vec_t;

    vec_t byp_tab[5];
    vec_t att_tab[6];

    rx_agc_64k #(
        .WIN_LOG2(6), .TARGET(16'd8192), .HYST(16'd1024), .STEP_SH(4),
        .GAIN_INIT(16'h1000), .GAIN_MIN(16'h0100), .LOCK_CNT(4)
    ) dut (
        .clk_200m(clk), .cfg_rst(rst),
        .data_64k_i_in(di), .data_64k_q_in(dq), .data_64k_in_en(den),
        .agc_bypass(byp), .agc_freeze(frz),
        .data_agc_i_out(oi), .data_agc_q_out(oq), .data_agc_out_en(oen),
        .agc_gain(gain), .agc_lock(lock)
    );

    always #2.5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // One strobe; waits (bounded) for the output strobe and checks latency and data.
    task automatic send(input logic signed [15:0] i, input logic signed [15:0] q,
                        input int ei, input int eq, input string nm);
        int lat;
        di  = i;
        dq  = q;
        den = 1'b1;
        tick();
        den = 1'b0;
        lat = 1;
        while (!oen && lat < 8) begin
            tick();
            lat++;
        end
        if (!oen) begin
            check({nm, " out_en timeout"}, 0, 1);
        end else begin
            check({nm, " latency"}, lat, 3);
            check({nm, " I"}, int'($signed(oi)), ei);
            check({nm, " Q"}, int'($signed(oq)), eq);
        end
    endtask

    task automatic do_reset();
        den = 1'b0;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        int g, lc, o, mean, post, w;
        bit locked;

        byp_tab[0] = '{16'sd1234,  -16'sd5678, 1234,  -5678};
        byp_tab[1] = '{16'sd32767, -16'sd32768, 32767, -32768};
        byp_tab[2] = '{16'sd0,     16'sd0,     0,     0};
        byp_tab[3] = '{-16'sd1,    16'sd1,     -1,    1};
        byp_tab[4] = '{16'sd100,   -16'sd100,  100,   -100};

        // Gain 0x0F00 (0.9375): round half up after scaling.
        att_tab[0] = '{16'sd1,     -16'sd1,     1,     -1};
        att_tab[1] = '{16'sd2,     -16'sd2,     2,     -2};
        att_tab[2] = '{16'sd3,     -16'sd3,     3,     -3};
        att_tab[3] = '{16'sd1000,  -16'sd1000,  938,   -937};
        att_tab[4] = '{16'sd32767, -16'sd32768, 30719, -30720};
        att_tab[5] = '{16'sd16384, 16'sd16384,  15360, 15360};

        // Reset state
        rst = 1'b1;
        repeat (5) tick();
        rst = 1'b0;
        tick();
        tick();
        check("rst I", int'(oi), 0);
        check("rst Q", int'(oq), 0);
        check("rst out_en", int'(oen), 0);
        check("rst gain", int'(gain), 'h1000);
        check("rst lock", int'(lock), 0);

        // Bypass: unity gain, loop idle
        byp = 1'b1;
        for (int k = 0; k < 5; k++)
            send(byp_tab[k].i, byp_tab[k].q, byp_tab[k].ei, byp_tab[k].eq, $sformatf("byp[%0d]", k));
        di  = 16'd16384;
        dq  = 16'd16384;
        den = 1'b1;
        repeat (200) tick();
        den = 1'b0;
        repeat (6) tick();
        check("byp gain hold", int'(gain), 'h1000);
        check("byp lock hold", int'(lock), 0);
        byp = 1'b0;

        // Attenuate: first window at unity, then one downward step
        for (int k = 0; k < 64; k++)
            send(16'sd16384, 16'sd16384, 16384, 16384, "att");
        tick();
        tick();
        check("att gain at m+2", int'(gain), 'h1000);
        tick();
        check("att gain at m+3", int'(gain), 'h0F00);
        check("att lock", int'(lock), 0);

        // Rounding at gain 0x0F00 with the loop frozen
        frz = 1'b1;
        for (int k = 0; k < 6; k++)
            send(att_tab[k].i, att_tab[k].q, att_tab[k].ei, att_tab[k].eq, $sformatf("rnd[%0d]", k));
        check("frz gain hold", int'(gain), 'h0F00);
        frz = 1'b0;

        // Amplify and lock with I=Q=1000
        do_reset();
        g = 'h1000;
        lc = 0;
        post = 0;
        locked = 1'b0;
        w = 0;
        while (w < 60 && post < 2) begin
            o = (1000 * g + 2048) >>> 12;
            for (int k = 0; k < 64; k++)
                send(16'sd1000, 16'sd1000, o, o, "amp");
            mean = 2 * o;
            if (mean > 9216) begin
                g = g - (g >>> 4);
                if (g < 'h100) g = 'h100;
                lc = 0;
            end else if (mean < 7168) begin
                g = g + (g >>> 4) + 1;
                if (g > 'hFFFF) g = 'hFFFF;
                lc = 0;
            end else if (lc < 4) begin
                lc++;
            end
            tick();
            tick();
            check($sformatf("amp lock before upd w%0d", w), int'(lock), locked ? 1 : 0);
            tick();
            if (w == 0)
                check("amp first gain", int'(gain), 'h1101);
            check($sformatf("amp gain w%0d", w), int'(gain), g);
            check($sformatf("amp lock w%0d", w), int'(lock), (lc == 4) ? 1 : 0);
            if (lc == 4) begin
                locked = 1'b1;
                post++;
            end
            w++;
        end
        check("amp locked", int'(lock), 1);

        // Clamp at 0xFFFF with zero input, then output saturation
        do_reset();
        di = '0;
        dq = '0;
        for (int k = 0; k < 80; k++) begin
            den = 1'b1;
            repeat (64) tick();
            den = 1'b0;
            repeat (6) tick();
        end
        check("clamp gain", int'(gain), 'hFFFF);
        check("clamp zero out I", int'(oi), 0);
        check("clamp zero out Q", int'(oq), 0);
        send(16'sd4096, -16'sd4096, 32767, -32768, "sat+");
        send(-16'sd4096, 16'sd4096, -32768, 32767, "sat-");

        // Mid-window reset with two samples in flight
        do_reset();
        for (int k = 0; k < 30; k++)
            send(16'sd16384, 16'sd16384, 16384, 16384, "pre");
        di  = 16'd16384;
        dq  = 16'd16384;
        den = 1'b1;
        tick();
        tick();
        den = 1'b0;
        rst = 1'b1;
        tick();
        check("flush out_en", int'(oen), 0);
        rst = 1'b0;
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 6; k++) begin
                tick();
                if (oen) seen++;
            end
            check("flush no strobe", seen, 0);
        end
        check("flush gain", int'(gain), 'h1000);
        for (int k = 0; k < 63; k++)
            send(16'sd16384, 16'sd16384, 16384, 16384, "post");
        repeat (4) tick();
        check("no early update", int'(gain), 'h1000);
        send(16'sd16384, 16'sd16384, 16384, 16384, "post64");
        repeat (3) tick();
        check("fresh window update", int'(gain), 'h0F00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
